// File: rtl/roce_qp_pkg.sv
// Shared RoCE QP definitions: QP state encodings, QPN base, RC opcodes,
// the WR-issuer FSM state type and the local-QPN range check.
package roce_qp_pkg;

    localparam logic [2:0] QP_STATE_INIT  = 3'd0;
    localparam logic [2:0] QP_STATE_RTR   = 3'd1;
    localparam logic [2:0] QP_STATE_RTS   = 3'd2;
    localparam logic [2:0] QP_STATE_ERROR = 3'd3;

    localparam logic [23:0] QPN_BASE = 24'd256;

    localparam logic [7:0] RC_RDMA_WRITE_FIRST  = 8'h06;
    localparam logic [7:0] RC_RDMA_WRITE_MIDDLE = 8'h07;
    localparam logic [7:0] RC_RDMA_WRITE_LAST   = 8'h08;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_WAIT_CTX,
        ST_SEND_TX,
        ST_UPDATE,
        ST_GUARD
    } wr_state_e;

    // Local QPNs live in 256 .. 256 + 2**width - 1.
    function automatic logic qpn_is_valid(input logic [23:0] qpn, input int unsigned width);
        return (qpn[23:8] == QPN_BASE[23:8]) && ((qpn[7:0] >> width) == 8'd0);
    endfunction

endpackage

// File: rtl/roce_wr_issuer.sv
// RDMA WRITE work-request front end: validates a WR, reads the QP context,
// emits TX metadata and then tells the QP state module to advance its PSN.
module roce_wr_issuer
    import roce_qp_pkg::*;
#(
    parameter int MAX_QUEUE_PAIRS = 4,
    parameter int CTX_TIMEOUT     = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s_wr_valid,
    output logic        s_wr_ready,
    input  logic [23:0] s_wr_loc_qpn,
    input  logic [31:0] s_wr_length,
    input  logic [31:0] s_wr_addr_offset,
    input  logic        stop_transfer,

    output logic        m_qp_context_req,
    output logic [23:0] m_qp_local_qpn_req,
    input  logic        s_qp_req_context_valid,
    input  logic [2:0]  s_qp_req_state,
    input  logic [23:0] s_qp_req_rem_qpn,
    input  logic [23:0] s_qp_req_loc_qpn,
    input  logic [23:0] s_qp_req_rem_psn,
    input  logic [31:0] s_qp_req_r_key,
    input  logic [31:0] s_qp_req_rem_ip_addr,
    input  logic [63:0] s_qp_req_rem_addr,

    output logic        m_tx_meta_valid,
    input  logic        m_tx_meta_ready,
    output logic [23:0] m_tx_meta_loc_qpn,
    output logic [23:0] m_tx_meta_rem_qpn,
    output logic [23:0] m_tx_meta_start_psn,
    output logic [31:0] m_tx_meta_r_key,
    output logic [31:0] m_tx_meta_rem_ip_addr,
    output logic [31:0] m_tx_meta_length,
    output logic [63:0] m_tx_meta_rem_addr,

    output logic        m_dma_meta_valid,
    output logic [31:0] m_meta_dma_length,
    output logic [23:0] m_meta_rem_qpn,
    output logic [23:0] m_meta_loc_qpn,
    output logic [23:0] m_meta_rem_psn,

    output logic        err_invalid_qpn,
    output logic        err_zero_len,
    output logic        err_qp_not_rts,
    output logic        err_ctx_timeout
);

    localparam int unsigned QPN_IDX_W = $clog2(MAX_QUEUE_PAIRS);
    localparam int CNT_W = $clog2(CTX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CTX_TIMEOUT);

    wr_state_e        state_q, state_d;
    logic [23:0]      wr_qpn_q, wr_qpn_d;
    logic [31:0]      wr_len_q, wr_len_d;
    logic [31:0]      wr_off_q, wr_off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       guard_q, guard_d;
    logic [23:0]      ctx_rem_qpn_q, ctx_rem_qpn_d;
    logic [23:0]      ctx_loc_qpn_q, ctx_loc_qpn_d;
    logic [23:0]      ctx_psn_q, ctx_psn_d;
    logic [31:0]      ctx_rkey_q, ctx_rkey_d;
    logic [31:0]      ctx_ip_q, ctx_ip_d;
    logic [63:0]      ctx_addr_q, ctx_addr_d;
    logic             wr_hs;

    assign s_wr_ready = (state_q == ST_IDLE) && !stop_transfer && !rst;
    assign wr_hs      = s_wr_valid && s_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_qpn_q      <= '0;
            wr_len_q      <= '0;
            wr_off_q      <= '0;
            cnt_q         <= '0;
            guard_q       <= '0;
            ctx_rem_qpn_q <= '0;
            ctx_loc_qpn_q <= '0;
            ctx_psn_q     <= '0;
            ctx_rkey_q    <= '0;
            ctx_ip_q      <= '0;
            ctx_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_qpn_q      <= wr_qpn_d;
            wr_len_q      <= wr_len_d;
            wr_off_q      <= wr_off_d;
            cnt_q         <= cnt_d;
            guard_q       <= guard_d;
            ctx_rem_qpn_q <= ctx_rem_qpn_d;
            ctx_loc_qpn_q <= ctx_loc_qpn_d;
            ctx_psn_q     <= ctx_psn_d;
            ctx_rkey_q    <= ctx_rkey_d;
            ctx_ip_q      <= ctx_ip_d;
            ctx_addr_q    <= ctx_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_qpn_d      = wr_qpn_q;
        wr_len_d      = wr_len_q;
        wr_off_d      = wr_off_q;
        cnt_d         = cnt_q;
        guard_d       = guard_q;
        ctx_rem_qpn_d = ctx_rem_qpn_q;
        ctx_loc_qpn_d = ctx_loc_qpn_q;
        ctx_psn_d     = ctx_psn_q;
        ctx_rkey_d    = ctx_rkey_q;
        ctx_ip_d      = ctx_ip_q;
        ctx_addr_d    = ctx_addr_q;

        m_qp_context_req      = 1'b0;
        m_qp_local_qpn_req    = '0;
        m_tx_meta_valid       = 1'b0;
        m_tx_meta_loc_qpn     = '0;
        m_tx_meta_rem_qpn     = '0;
        m_tx_meta_start_psn   = '0;
        m_tx_meta_r_key       = '0;
        m_tx_meta_rem_ip_addr = '0;
        m_tx_meta_length      = '0;
        m_tx_meta_rem_addr    = '0;
        m_dma_meta_valid      = 1'b0;
        m_meta_dma_length     = '0;
        m_meta_rem_qpn        = '0;
        m_meta_loc_qpn        = '0;
        m_meta_rem_psn        = '0;
        err_invalid_qpn       = 1'b0;
        err_zero_len          = 1'b0;
        err_qp_not_rts        = 1'b0;
        err_ctx_timeout       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_hs) begin
                    wr_qpn_d = s_wr_loc_qpn;
                    wr_len_d = s_wr_length;
                    wr_off_d = s_wr_addr_offset;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!qpn_is_valid(wr_qpn_q, QPN_IDX_W)) begin
                    err_invalid_qpn = 1'b1;
                    state_d         = ST_IDLE;
                end else if (wr_len_q == 32'd0) begin
                    err_zero_len = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                m_qp_context_req   = 1'b1;
                m_qp_local_qpn_req = wr_qpn_q;
                cnt_d              = '0;
                state_d            = ST_WAIT_CTX;
            end
            ST_WAIT_CTX: begin
                cnt_d = cnt_q + 1'b1;
                // A response on the timeout cycle still counts.
                if (s_qp_req_context_valid) begin
                    if (s_qp_req_state != QP_STATE_RTS) begin
                        err_qp_not_rts = 1'b1;
                        state_d        = ST_IDLE;
                    end else begin
                        ctx_rem_qpn_d = s_qp_req_rem_qpn;
                        ctx_loc_qpn_d = s_qp_req_loc_qpn;
                        ctx_psn_d     = s_qp_req_rem_psn;
                        ctx_rkey_d    = s_qp_req_r_key;
                        ctx_ip_d      = s_qp_req_rem_ip_addr;
                        ctx_addr_d    = s_qp_req_rem_addr + {32'd0, wr_off_q};
                        state_d       = ST_SEND_TX;
                    end
                end else if (cnt_d == CNT_LAST) begin
                    err_ctx_timeout = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            ST_SEND_TX: begin
                m_tx_meta_valid       = 1'b1;
                m_tx_meta_loc_qpn     = ctx_loc_qpn_q;
                m_tx_meta_rem_qpn     = ctx_rem_qpn_q;
                m_tx_meta_start_psn   = ctx_psn_q;
                m_tx_meta_r_key       = ctx_rkey_q;
                m_tx_meta_rem_ip_addr = ctx_ip_q;
                m_tx_meta_length      = wr_len_q;
                m_tx_meta_rem_addr    = ctx_addr_q;
                if (m_tx_meta_ready) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                m_dma_meta_valid  = 1'b1;
                m_meta_dma_length = wr_len_q;
                m_meta_rem_qpn    = ctx_rem_qpn_q;
                m_meta_loc_qpn    = ctx_loc_qpn_q;
                m_meta_rem_psn    = ctx_psn_q;
                guard_d           = '0;
                state_d           = ST_GUARD;
            end
            ST_GUARD: begin
                // Gives the QP state module time to write back the new PSN.
                guard_d = guard_q + 1'b1;
                if (guard_q == 2'd2) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            m_qp_context_req      = 1'b0;
            m_qp_local_qpn_req    = '0;
            m_tx_meta_valid       = 1'b0;
            m_tx_meta_loc_qpn     = '0;
            m_tx_meta_rem_qpn     = '0;
            m_tx_meta_start_psn   = '0;
            m_tx_meta_r_key       = '0;
            m_tx_meta_rem_ip_addr = '0;
            m_tx_meta_length      = '0;
            m_tx_meta_rem_addr    = '0;
            m_dma_meta_valid      = 1'b0;
            m_meta_dma_length     = '0;
            m_meta_rem_qpn        = '0;
            m_meta_loc_qpn        = '0;
            m_meta_rem_psn        = '0;
            err_invalid_qpn       = 1'b0;
            err_zero_len          = 1'b0;
            err_qp_not_rts        = 1'b0;
            err_ctx_timeout       = 1'b0;
        end
    end

endmodule
